arb_req_agent: RTL

Requester-side front end for the fixed-priority 4-way arbiter (priority 3 > 2 > 1 > 0, registered grant). The block accepts a burst job per channel, raises that channel's request line, counts granted beats, tolerates preemption by higher-priority channels, and drops the request after the last beat. It also flags starvation and protocol errors on the grant bus. It sits between the client engines and the arbiter's REQ/GNT ports.

---
 rtl/arb_req_pkg.sv | 21 ++
 rtl/arb_req_channel.sv | 108 ++++++++++
 rtl/arb_req_agent.sv | 75 +++++++
 3 files changed

// File: rtl/arb_req_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_req_pkg
//  Description : Shared types and default sizing for the arbiter request
//                agent: per-channel state encoding and default parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_req_pkg;

   localparam int NCH_DEF        = 4;
   localparam int LEN_W_DEF      = 4;
   localparam int STARVE_LIM_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_RELEASE = 2'd2
   } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_req_channel.sv
`default_nettype none
// ============================================================================
//  Module      : arb_req_channel
//  Description : One requester channel. Accepts a burst job, holds its
//                request line until the last granted beat, then drops the
//                request for one cycle before becoming idle again.
//  Ports       : clk, rst        clock / async active-high reset
//                job_valid       job offer
//                job_len         beat count (0 means 2^LEN_W)
//                job_ready       channel idle, able to accept
//                gnt             grant bit for this channel
//                req             request line (decoded from state register)
//                beat, done      granted beat / final beat (combinational)
//                starve          waiting too long without a beat
//  Revision    : 1.0  initial release
// ============================================================================
module arb_req_channel
   import arb_req_pkg::*;
#(
   parameter int LEN_W      = LEN_W_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   input  logic [LEN_W-1:0] job_len,
   output logic             job_ready,
   input  logic             gnt,
   output logic             req,
   output logic             beat,
   output logic             done,
   output logic             starve
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] C_LIM     = CNT_W'(STARVE_LIM);
   localparam logic [LEN_W:0]   C_REM_ONE = {{LEN_W{1'b0}}, 1'b1};
   localparam logic [LEN_W:0]   C_REM_MAX = {1'b1, {LEN_W{1'b0}}};

   ch_state_t        r_state;
   ch_state_t        w_state_nxt;
   logic [LEN_W:0]   r_remaining;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_accept;
   logic             w_last;

   assign w_accept = job_valid && (r_state == ST_IDLE);
   assign w_last   = (r_remaining == C_REM_ONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (job_valid)     w_state_nxt = ST_ACTIVE;
         ST_ACTIVE:  if (gnt && w_last) w_state_nxt = ST_RELEASE;
         ST_RELEASE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs. A grant in RELEASE is the arbiter's stale registered grant for
   // our last beat and must not count. starve is masked in the beat cycle so
   // it falls exactly when the wait ends.
   always_comb begin
      job_ready = 1'b0;
      req       = 1'b0;
      beat      = 1'b0;
      done      = 1'b0;
      starve    = 1'b0;
      case (r_state)
         ST_IDLE:   job_ready = 1'b1;
         ST_ACTIVE: begin
            req    = 1'b1;
            beat   = gnt;
            done   = gnt && w_last;
            starve = (r_wait_cnt >= C_LIM) && !gnt;
         end
         default: ;
      endcase
   end

   // Remaining-beat and wait counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_remaining <= '0;
         r_wait_cnt  <= '0;
      end else if (w_accept) begin
         r_remaining <= (job_len == '0) ? C_REM_MAX : {1'b0, job_len};
         r_wait_cnt  <= '0;
      end else if (beat) begin
         r_remaining <= r_remaining - C_REM_ONE;
         r_wait_cnt  <= '0;
      end else if ((r_state == ST_ACTIVE) && (r_wait_cnt != C_LIM)) begin
         r_wait_cnt  <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: rtl/arb_req_agent.sv
`default_nettype none
// ============================================================================
//  Module      : arb_req_agent
//  Description : Requester-side front end for a fixed-priority NCH-way
//                arbiter. One channel FSM per request line plus a sticky
//                protocol-error flag watching the grant bus.
//  Ports       : clk, rst        clock / async active-high reset
//                job_valid/len   per-channel job offers
//                job_ready       per-channel idle indication
//                REQ / GNT       arbiter request / grant lines
//                beat, done      per-channel beat / final beat
//                starve          per-channel starvation flag
//                err             sticky: multi-hot grant or grant to idle ch
//  Revision    : 1.0  initial release
// ============================================================================
module arb_req_agent
   import arb_req_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       job_valid,
   input  logic [NCH*LEN_W-1:0] job_len,
   output logic [NCH-1:0]       job_ready,
   output logic [NCH-1:0]       REQ,
   input  logic [NCH-1:0]       GNT,
   output logic [NCH-1:0]       beat,
   output logic [NCH-1:0]       done,
   output logic [NCH-1:0]       starve,
   output logic                 err
);

   localparam logic [NCH-1:0] C_ONE = {{(NCH-1){1'b0}}, 1'b1};

   logic w_multi_hot;
   logic w_idle_gnt;
   logic r_err;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      arb_req_channel #(
         .LEN_W      (LEN_W),
         .STARVE_LIM (STARVE_LIM)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .job_valid (job_valid[i]),
         .job_len   (job_len[i*LEN_W +: LEN_W]),
         .job_ready (job_ready[i]),
         .gnt       (GNT[i]),
         .req       (REQ[i]),
         .beat      (beat[i]),
         .done      (done[i]),
         .starve    (starve[i])
      );
   end

   // x & (x-1) clears the lowest set bit; anything left means >1 bit high.
   assign w_multi_hot = |(GNT & (GNT - C_ONE));
   assign w_idle_gnt  = |(GNT & job_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_multi_hot || w_idle_gnt) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;

endmodule
`default_nettype wire
